morse_tone_player: RTL
======================

# morse_tone_player

Timing and tone stage of the Morse encoder, placed directly downstream of the keypad/switch capture logic. It accepts one Morse character per valid/ready handshake as an element count plus dot/dash bit pattern. It then drives the buzzer with correctly timed dots, dashes, element gaps and character/word gaps at one of two speeds. While a character is playing, it reports the current element index for the LEDs.

## Interface
Parameters:
- UNIT_SLOW, 10_000_000, clock cycles per Morse time unit at normal speed (100 ms at 100 MHz)
- UNIT_FAST, 5_000_000, clock cycles per time unit when speed_adjust=1
- TONE_HALF, 100_000, clock cycles per half-period of the buzzer square wave (500 Hz at 100 MHz)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-low reset; sampled on rising clk
- sym_valid  in  1  upstream has a character to play
- sym_len  in  3  number of elements, 0..5; 0 means word space; 6 and 7 are clamped to 5
- sym_bits  in  5  element pattern; bit i is element i (played i=0 first); 1=dash, 0=dot; bits at or above sym_len are ignored
- sym_last  in  1  character ends a word; selects a 7-unit trailing gap instead of 3 units
- speed_adjust  in  1  1 selects UNIT_FAST; sampled only at acceptance
- sym_ready  out  1  high exactly when state is IDLE; a transfer occurs on a clk edge with sym_valid&&sym_ready&&rst
- beep  out  1  buzzer drive; square wave during tones, 0 otherwise
- busy  out  1  inverse of sym_ready
- elem_idx  out  3  index of the element currently sounding or gapping; 0 in IDLE

## Operation
- Reset (rst=0 at an edge): state IDLE, beep=0, elem_idx=0, unit and tone counters cleared. This gives sym_ready=1 and busy=0. A handshake is ignored while rst=0. Reset mid-character aborts immediately, with no residual tone.
- States: IDLE, TONE, EGAP, CGAP.
- IDLE: on transfer, the block latches len (clamped), bits, last, and U (UNIT_SLOW or UNIT_FAST), and sets elem_idx=0.
  - len≥1: go to TONE.
  - len=0: go to CGAP with 7 units.
- TONE: lasts U cycles for a dot or 3U cycles for a dash.
  - If elem_idx<len-1, go to EGAP.
  - Otherwise, go to CGAP with 3 units (last=0) or 7 units (last=1).
- EGAP: silent for U cycles. Then increment elem_idx and go to TONE.
- CGAP: silent for the selected units×U cycles, then go to IDLE.
- Tone generation:
  - The tone counter restarts at the start of each TONE.
  - beep=1 in the first TONE cycle and toggles after every TONE_HALF cycles.
  - beep is forced to 0 in all other states, including the cycle of exit from TONE.
- Counters: the unit counter is wide enough for 7×UNIT_SLOW. There is no wrap inside a state; the counter is cleared on every state change.
- Latched fields are immune to input changes after acceptance. sym_valid held high during playback does not start a new character until IDLE.

## Timing
- Accept edge E0. State occupancy covers cycles 1..N after E0, where N = units×U and units = Σ(1 per dot, 3 per dash) + (len−1) + (3 or 7).
  - For len=0, units = 7.
  - sym_ready=1 from cycle N+1 onward.
- Back-to-back: if sym_valid is already high, the next character is accepted on the edge ending cycle N+1. That inserts exactly one IDLE cycle between characters.
- beep latency: beep is high in cycle 1 after E0 for any len≥1 character.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.

## Test plan
(Parameters for all scenarios: UNIT_SLOW=8, UNIT_FAST=4, TONE_HALF=2.)
- Reset: hold rst=0 for 3 cycles with sym_valid=1. Required: beep=0, sym_ready=1, busy=0, elem_idx=0, and no acceptance. Release rst and check acceptance on the next edge.
- "A": len=2, bits=2'b10, last=0, speed=1.
  - beep toggles 1,1,0,0 over cycles 1–4.
  - Silent over cycles 5–8; elem_idx=1 from cycle 9.
  - Tone over cycles 9–20, then silent over cycles 21–32.
  - sym_ready=1 in cycle 33.
- Word gap: "E" (len=1, bits=0, last=1, speed=0). Tone over cycles 1–8, silence over cycles 9–64, sym_ready in cycle 65. Repeat with last=0: sym_ready in cycle 33.
- Space and clamp:
  - len=0 with speed=1 gives 28 silent cycles, with beep never 1.
  - len=7, bits=5'b11111 plays 5 dashes, with elem_idx reaching 4.
- Mid-operation behaviour:
  - Change speed_adjust and sym_bits during playback: timing is unchanged.
  - Assert rst=0 during the second tone: next cycle beep=0, sym_ready=1, elem_idx=0.
- Back-to-back: keep sym_valid high with two "E" characters (speed=1, last=0). The second beep starts exactly 2 cycles after the first character's final gap cycle.

Source files
------------

// File: rtl/morse_tone_player_if.sv
// morse_tone_player_if: character handshake between keypad capture and the Morse tone player
interface morse_tone_player_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [2:0] sym_len;
    logic [4:0] sym_bits;
    logic       sym_last;
    logic       speed_adjust;
    modport master (output sym_valid, sym_len, sym_bits, sym_last, speed_adjust, input sym_ready);
    modport slave  (input sym_valid, sym_len, sym_bits, sym_last, speed_adjust, output sym_ready);
endinterface

// File: rtl/morse_tone_player.sv
// morse_tone_player: times Morse dots, dashes and gaps and drives a square-wave buzzer
module morse_tone_player #(
    parameter int UNIT_SLOW = 10_000_000,
    parameter int UNIT_FAST = 5_000_000,
    parameter int TONE_HALF = 100_000
) (
    input  logic                  clk,
    input  logic                  rst,
    morse_tone_player_if.slave    sym,
    output logic                  beep,
    output logic                  busy,
    output logic [2:0]            elem_idx
);
    localparam int CW = $clog2(7 * UNIT_SLOW + 1);
    localparam int TW = $clog2(TONE_HALF + 1);
    typedef enum logic [1:0] {IDLE, TONE, EGAP, CGAP} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, unit, dur;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    idx_q, idx_d, len_q, len_d, len_in;
    logic [4:0]    bits_q, bits_d;
    logic          beep_q, beep_d, last_q, last_d, fast_q, fast_d, done;
    always_comb begin
        len_in  = (sym.sym_len > 3'd5) ? 3'd5 : sym.sym_len;
        unit    = fast_q ? CW'(UNIT_FAST) : CW'(UNIT_SLOW);
        dur     = (state_q == TONE && bits_q[idx_q]) ? unit * CW'(3) :
                  (state_q == CGAP) ? unit * (last_q ? CW'(7) : CW'(3)) : unit;
        done    = cnt_q == dur - CW'(1);
        state_d = state_q;
        cnt_d   = done ? '0 : cnt_q + CW'(1);
        tcnt_d  = (tcnt_q == TW'(TONE_HALF - 1)) ? '0 : tcnt_q + TW'(1);
        beep_d  = 1'b0;
        idx_d   = idx_q;
        len_d   = len_q;
        bits_d  = bits_q;
        last_d  = last_q;
        fast_d  = fast_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                tcnt_d = '0;
                if (sym.sym_valid) begin
                    len_d   = len_in;
                    bits_d  = sym.sym_bits;
                    last_d  = sym.sym_last || len_in == 3'd0;
                    fast_d  = sym.speed_adjust;
                    idx_d   = 3'd0;
                    state_d = (len_in == 3'd0) ? CGAP : TONE;
                    beep_d  = len_in != 3'd0;
                end
            end
            TONE: begin
                beep_d = done ? 1'b0 : (tcnt_q == TW'(TONE_HALF - 1)) ? ~beep_q : beep_q;
                if (done) state_d = (idx_q < len_q - 3'd1) ? EGAP : CGAP;
            end
            EGAP: if (done) begin
                state_d = TONE;
                idx_d   = idx_q + 3'd1;
                beep_d  = 1'b1;
                tcnt_d  = '0;
            end
            CGAP: if (done) begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            beep_q  <= 1'b0;
            idx_q   <= 3'd0;
            len_q   <= 3'd0;
            bits_q  <= 5'd0;
            last_q  <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            beep_q  <= beep_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            bits_q  <= bits_d;
            last_q  <= last_d;
            fast_q  <= fast_d;
        end
    end
    assign sym.sym_ready = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign beep          = beep_q;
    assign elem_idx      = idx_q;
endmodule
